float2int_pipe: RTL and testbench
=================================

Name: float2int_pipe

Overview:
- Parametrised, pipelined float-to-signed-integer converter. Successor to the single-stage converter.
- Generalised over exponent, mantissa and integer widths.
- Adds selectable rounding modes, true two's-complement output, signed saturation, IEEE exception flags and a valid/ready stream interface with backpressure.
- Sits between the floating-point estimation datapath and the integer error-count/accumulator logic.

Parameters:
- EXP_WID, 8, exponent field width; bias = 2^(EXP_WID-1)-1.
- MAN_WID, 23, stored fraction width (hidden bit implicit).
- INT_WID, 32, output integer width, two's complement.
- FP_WID, 1+EXP_WID+MAN_WID, derived and not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word this cycle.
- in_fp  in  FP_WID  IEEE-style float: sign, exponent, fraction.
- in_rm  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_int  out  INT_WID  signed integer result.
- out_ovf  out  1  result saturated because the magnitude is out of range.
- out_inv  out  1  input was NaN or infinity.
- out_inx  out  1  result differs from the input value (rounded or saturated).

Behaviour:
- Reset (asynchronous, any time, including mid-flight): all stage valids clear. out_valid=0, out_int=0, all flags 0. In-flight words are discarded. in_ready=1 one cycle after reset is released.
- Pipeline has three register stages with a global stall.
  - adv = out_ready | ~out_valid.
  - in_ready = adv.
  - A word transfers on in_valid & in_ready.
  - Latency from transfer to out_valid is exactly 3 cycles with no stall. Throughput is 1 word per cycle.
- Stall: while out_valid & ~out_ready, all stages hold their contents, out_int and the flags are stable, and in_ready=0. Bubbles are not compressed.
- Stage 1 (unpack/classify) registers:
  - sign and rounding mode;
  - mantissa with hidden bit, where hidden bit = (exp != 0);
  - unbiased exponent e = exp - bias, computed signed with width EXP_WID+1;
  - class: zero, subnormal, normal, inf, nan.
- Stage 2 (align): builds a magnitude of INT_WID+1 integer bits plus guard bit G and sticky bit S.
  - e < -1: integer part = 0, G = 0, S = (mantissa != 0).
  - e = -1: integer part = 0, G = 1, S = OR of the remaining fraction bits.
  - e >= INT_WID: pre-overflow is set; no shift is performed.
- Stage 3 (round/negate/saturate):
  - Round-up condition by mode:
    - RNE: G & (S | lsb).
    - RTZ: never.
    - toward +inf: ~sign & (G|S).
    - toward -inf: sign & (G|S).
  - Add the increment, then negate if sign is set.
- Saturation:
  - Positive out-of-range gives 2^(INT_WID-1)-1.
  - Negative out-of-range gives -2^(INT_WID-1).
  - Exactly -2^(INT_WID-1) is representable: no ovf, no inx.
  - Overflow is also detected after the rounding increment (carry into bit INT_WID-1).
- Specials:
  - ±0 and ±subnormal follow the normal rounding path. -0 gives 0, never negative zero.
  - NaN gives max positive with inv=1.
  - +inf gives max positive with inv=1; -inf gives min negative with inv=1.
  - ovf=0 for NaN and inf.
- Flag rules: inx = (G|S) | ovf | inv. The flags are registered with out_int and valid only while out_valid=1.
- in_rm is sampled with the word and travels down the pipeline. Mixed modes back-to-back are legal.

Decomposition:
- Shared package float2int_pkg holds:
  - rounding-mode localparams RM_RNE, RM_RTZ, RM_RUP, RM_RDN;
  - class encoding constants;
  - a bias function of EXP_WID;
  - saturation constant functions for INT_WID.
- One natural sub-module: f2i_round_sat, the stage-3 combinational round/negate/saturate logic, exhaustively testable on its own.
- Stages 1 and 2 stay in float2int_pipe.

Test Plan:
- RNE ties: 0x3FC00000 (1.5) gives 2 with inx=1. 0x40200000 (2.5) gives 2 with inx=1. 0x40400000 (3.0) gives 3 with inx=0.
- Directed modes on 0xC0200000 (-2.5):
  - RTZ gives 0xFFFFFFFE.
  - toward +inf gives 0xFFFFFFFE.
  - toward -inf gives 0xFFFFFFFD.
  - RNE gives 0xFFFFFFFE.
  - Subnormal 0x00000001 with toward +inf gives 1, inx=1.
- Range edges:
  - 0x4F000000 (2^31) gives 0x7FFFFFFF, ovf=1.
  - 0xCF000000 (-2^31) gives 0x80000000, ovf=0, inx=0.
  - 0x4EFFFFFF gives 0x7FFFFF80, no flags.
- Specials:
  - 0x7FC00000 gives 0x7FFFFFFF, inv=1.
  - 0xFF800000 gives 0x80000000, inv=1.
  - 0x80000000 (-0) gives 0, no flags.
- Stream: 10 back-to-back words. out_ready low for 4 cycles mid-burst; in_ready drops and out_int holds. Order is preserved, no loss or duplication, and first output arrives 3 cycles after the first transfer.
- Reset mid-burst with 3 words in flight: out_valid=0 immediately (asynchronous). No stale word appears after release. The next accepted word appears 3 cycles later.

Source files
------------

// File: rtl/float2int_pkg.sv
// Shared constants and helpers for the pipelined float-to-integer converter.
package float2int_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fp_class_e;

  function automatic int unsigned fp_bias(input int unsigned exp_wid);
    return (32'd1 << (exp_wid - 1)) - 32'd1;
  endfunction

  // Saturation limits as 64-bit patterns; callers keep the low INT_WID bits.
  function automatic logic [63:0] sat_max(input int unsigned int_wid);
    return (64'd1 << (int_wid - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned int_wid);
    return 64'd1 << (int_wid - 1);
  endfunction

endpackage

// File: rtl/float2int_if.sv
// Stream interface for the converter: float words in, integers plus flags out.
// A word moves on any rising edge where valid & ready are both high; valid
// never waits on ready, and payload is held while valid & ~ready.
interface float2int_if #(
  parameter int FP_WID  = 32,
  parameter int INT_WID = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [FP_WID-1:0]  in_fp;
  logic [1:0]         in_rm;
  logic               out_valid;
  logic               out_ready;
  logic [INT_WID-1:0] out_int;
  logic               out_ovf;
  logic               out_inv;
  logic               out_inx;

  modport master (
    output in_valid, in_fp, in_rm, out_ready,
    input  in_ready, out_valid, out_int, out_ovf, out_inv, out_inx
  );

  modport slave (
    input  in_valid, in_fp, in_rm, out_ready,
    output in_ready, out_valid, out_int, out_ovf, out_inv, out_inx
  );
endinterface

// File: rtl/f2i_round_sat.sv
// Final-stage combinational logic: rounding increment, negation and signed
// saturation of an aligned magnitude, plus exception flags.
module f2i_round_sat
  import float2int_pkg::*;
#(
  parameter int INT_WID = 32
) (
  input  logic               sign,
  input  logic [1:0]         rm,
  input  logic [INT_WID:0]   mag,
  input  logic               g,
  input  logic               s,
  input  logic               povf,
  input  logic               is_nan,
  input  logic               is_inf,
  output logic [INT_WID-1:0] res,
  output logic               ovf,
  output logic               inv,
  output logic               inx
);
  localparam logic [63:0] MAX64 = sat_max(INT_WID);
  localparam logic [63:0] MIN64 = sat_min(INT_WID);
  localparam logic [INT_WID-1:0] MAX_POS = MAX64[INT_WID-1:0];
  localparam logic [INT_WID-1:0] MIN_NEG = MIN64[INT_WID-1:0];

  logic           round_up;
  logic [INT_WID:0] sum;
  logic           rng_ovf;

  always_comb begin
    round_up = 1'b0;
    case (rm)
      RM_RNE:  round_up = g & (s | mag[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_RUP:  round_up = ~sign & (g | s);
      default: round_up = sign & (g | s);
    endcase

    sum = mag + {{INT_WID{1'b0}}, round_up};

    // Negative side may reach exactly 2^(INT_WID-1); positive side may not.
    if (sign) rng_ovf = sum[INT_WID] | (sum[INT_WID-1] & (|sum[INT_WID-2:0]));
    else      rng_ovf = |sum[INT_WID:INT_WID-1];

    inv = is_nan | is_inf;
    ovf = ~inv & (povf | rng_ovf);

    if (inv)       res = (is_nan | ~sign) ? MAX_POS : MIN_NEG;
    else if (ovf)  res = sign ? MIN_NEG : MAX_POS;
    else if (sign) res = -sum[INT_WID-1:0];
    else           res = sum[INT_WID-1:0];

    inx = g | s | ovf | inv;
  end
endmodule

// File: rtl/float2int_pipe.sv
// Three-stage float-to-signed-integer converter: unpack/classify, align,
// round/saturate. One global stall freezes every stage under backpressure.
module float2int_pipe
  import float2int_pkg::*;
#(
  parameter  int EXP_WID = 8,
  parameter  int MAN_WID = 23,
  parameter  int INT_WID = 32,
  localparam int FP_WID  = 1 + EXP_WID + MAN_WID
) (
  input logic        clk,
  input logic        rst,
  float2int_if.slave bus
);
  localparam int FW = MAN_WID + INT_WID + 1;
  localparam logic signed [EXP_WID:0] BIAS_S    = (EXP_WID+1)'(fp_bias(EXP_WID));
  localparam logic signed [EXP_WID:0] INT_WID_E = (EXP_WID+1)'(INT_WID);
  localparam logic signed [EXP_WID:0] E_M1      = '1;

  logic adv;
  logic out_valid_q;

  assign adv          = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = adv;

  // Stage 1: unpack and classify
  logic                      sign_in;
  logic [EXP_WID-1:0]        exp_in;
  logic [MAN_WID-1:0]        frac_in;
  logic signed [EXP_WID:0]   e_in;
  fp_class_e                 cls_in;

  assign sign_in = bus.in_fp[FP_WID-1];
  assign exp_in  = bus.in_fp[FP_WID-2:MAN_WID];
  assign frac_in = bus.in_fp[MAN_WID-1:0];
  assign e_in    = $signed({1'b0, exp_in}) - BIAS_S;

  always_comb begin
    cls_in = CLS_NORM;
    if (&exp_in)             cls_in = (|frac_in) ? CLS_NAN : CLS_INF;
    else if (exp_in == '0)   cls_in = (|frac_in) ? CLS_SUB : CLS_ZERO;
  end

  logic                    s1_valid, s1_sign;
  logic [1:0]              s1_rm;
  logic [MAN_WID:0]        s1_man;
  logic signed [EXP_WID:0] s1_e;
  fp_class_e               s1_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rm    <= RM_RNE;
      s1_man   <= '0;
      s1_e     <= '0;
      s1_cls   <= CLS_ZERO;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_sign  <= sign_in;
      s1_rm    <= bus.in_rm;
      s1_man   <= {(exp_in != '0), frac_in};
      s1_e     <= e_in;
      s1_cls   <= cls_in;
    end
  end

  // Stage 2: align into integer part + guard + sticky
  logic [FW-1:0]    shifted;
  logic [INT_WID:0] mag_a;
  logic             g_a, s_a, povf_a;

  always_comb begin
    shifted = FW'(s1_man) << $unsigned(s1_e);
    mag_a   = '0;
    g_a     = 1'b0;
    s_a     = 1'b0;
    povf_a  = 1'b0;
    if (s1_e >= INT_WID_E) begin
      povf_a = 1'b1;
    end else if (s1_e < E_M1) begin
      s_a = |s1_man;
    end else if (s1_e == E_M1) begin
      g_a = s1_man[MAN_WID];
      s_a = |s1_man[MAN_WID-1:0];
    end else begin
      mag_a = shifted[FW-1:MAN_WID];
      g_a   = shifted[MAN_WID-1];
      s_a   = |shifted[MAN_WID-2:0];
    end
  end

  logic             s2_valid, s2_sign, s2_g, s2_s, s2_povf, s2_nan, s2_inf;
  logic [1:0]       s2_rm;
  logic [INT_WID:0] s2_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_rm    <= RM_RNE;
      s2_mag   <= '0;
      s2_g     <= 1'b0;
      s2_s     <= 1'b0;
      s2_povf  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_rm    <= s1_rm;
      s2_mag   <= mag_a;
      s2_g     <= g_a;
      s2_s     <= s_a;
      s2_povf  <= povf_a;
      s2_nan   <= (s1_cls == CLS_NAN);
      s2_inf   <= (s1_cls == CLS_INF);
    end
  end

  // Stage 3: round, negate, saturate
  logic [INT_WID-1:0] res_r;
  logic               ovf_r, inv_r, inx_r;

  f2i_round_sat #(.INT_WID(INT_WID)) u_round_sat (
    .sign   (s2_sign),
    .rm     (s2_rm),
    .mag    (s2_mag),
    .g      (s2_g),
    .s      (s2_s),
    .povf   (s2_povf),
    .is_nan (s2_nan),
    .is_inf (s2_inf),
    .res    (res_r),
    .ovf    (ovf_r),
    .inv    (inv_r),
    .inx    (inx_r)
  );

  logic [INT_WID-1:0] out_int_q;
  logic               out_ovf_q, out_inv_q, out_inx_q;

  // Bubbles load zeros so result and flags read 0 whenever out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_inv_q   <= 1'b0;
      out_inx_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_valid;
      out_int_q   <= s2_valid ? res_r : '0;
      out_ovf_q   <= s2_valid & ovf_r;
      out_inv_q   <= s2_valid & inv_r;
      out_inx_q   <= s2_valid & inx_r;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_int   = out_int_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_inv   = out_inv_q;
  assign bus.out_inx   = out_inx_q;
endmodule

// File: tb/tb_float2int_pipe.sv
// Scoreboard bench for float2int_pipe: directed vectors, a stalled burst and
// an asynchronous reset with words in flight.
module tb_float2int_pipe;
  import float2int_pkg::*;

  localparam int W = 35;   // {out_int, ovf, inv, inx}
  localparam int N = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic         was_stall = 1'b0;
  logic [31:0]  held = '0;
  logic [W-1:0] mon_e;
  int           mon_t;

  float2int_if #(.FP_WID(32), .INT_WID(32)) bus();

  float2int_pipe #(.EXP_WID(8), .MAN_WID(23), .INT_WID(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors; flags are {ovf, inv, inx}
  logic [31:0] fp_t  [N] = '{32'h3FC00000, 32'h40200000, 32'h40400000, 32'hC0200000,
                             32'hC0200000, 32'hC0200000, 32'hC0200000, 32'h00000001,
                             32'h4F000000, 32'hCF000000, 32'h4EFFFFFF, 32'h7FC00000,
                             32'hFF800000, 32'h80000000, 32'h7F800000, 32'h3F000000,
                             32'h3F400000, 32'hBF400000, 32'hBF400000, 32'hCF000001,
                             32'h4F800000, 32'h00000001, 32'h3FFFFFFF};
  logic [1:0]  rm_t  [N] = '{RM_RNE, RM_RNE, RM_RNE, RM_RTZ, RM_RUP, RM_RDN, RM_RNE, RM_RUP,
                             RM_RNE, RM_RNE, RM_RNE, RM_RNE, RM_RNE, RM_RNE, RM_RTZ, RM_RNE,
                             RM_RNE, RM_RUP, RM_RDN, RM_RTZ, RM_RNE, RM_RDN, RM_RUP};
  logic [31:0] res_t [N] = '{32'h00000002, 32'h00000002, 32'h00000003, 32'hFFFFFFFE,
                             32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000001,
                             32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80, 32'h7FFFFFFF,
                             32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000,
                             32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
                             32'h7FFFFFFF, 32'h00000000, 32'h00000002};
  logic [2:0]  flg_t [N] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                             3'b101, 3'b000, 3'b000, 3'b011, 3'b011, 3'b000, 3'b011, 3'b001,
                             3'b001, 3'b001, 3'b001, 3'b101, 3'b101, 3'b001, 3'b001};
  // 1.0 .. 10.0
  logic [31:0] str_fp [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                               32'h41100000, 32'h41200000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] fp, input logic [1:0] rm,
                      input logic [W-1:0] e, input bit lat);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_fp    = fp;
    bus.in_rm    = rm;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready %b required 1 within 100 cycles", bus.in_ready);
    end else begin
      exp_q.push_back(e);
      lat_q.push_back(lat ? cyc : -1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stall holds.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h required no output", bus.out_int);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = lat_q.pop_front();
          chk("result", {bus.out_int, bus.out_ovf, bus.out_inv, bus.out_inx}, mon_e);
          if (mon_t >= 0) chk("latency", cyc - mon_t, 3);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", bus.in_ready, 0);
        if (was_stall) chk("stall_hold", bus.out_int, held);
        was_stall = 1'b1;
        held      = bus.out_int;
      end else begin
        was_stall = 1'b0;
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_fp     = '0;
    bus.in_rm     = RM_RNE;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_int", bus.out_int, 0);
    chk("rst_flags", {bus.out_ovf, bus.out_inv, bus.out_inx}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_rst", bus.in_ready, 1);

    for (int i = 0; i < N; i++) send(fp_t[i], rm_t[i], {res_t[i], flg_t[i]}, 1'b1);
    idle();
    drain();

    fork
      for (int i = 0; i < 10; i++) send(str_fp[i], RM_RNE, {32'(i + 1), 3'b000}, i == 0);
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle();
    drain();

    for (int i = 0; i < 3; i++) send(str_fp[i], RM_RNE, {32'(i + 1), 3'b000}, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1 chk("async_rst_valid", bus.out_valid, 0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_int", bus.out_int, 0);
    rst = 1'b0;
    send(32'h40A00000, RM_RNE, {32'd5, 3'b000}, 1'b1);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
